// File: rtl/cordic_sched.sv
// cordic_sched: shares one iterative CORDIC rotation core among NUM_REQ requesters.
// One operand triple is granted at a time. The core gets a single-cycle start pulse,
// the scheduler counts ITER iterations, captures the result and returns it on a
// valid/ready port tagged with the owning requester index.
// Build option: define CORDIC_SCHED_FIXED_PRI_EN for fixed priority (lowest asserted
// index wins, no rotating pointer) instead of the default round-robin arbitration.
module cordic_sched #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int ITER    = 16,
    parameter int IDW     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_x,
    input  logic [NUM_REQ*WIDTH-1:0] req_y,
    input  logic [NUM_REQ*WIDTH-1:0] req_z,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     core_valid,
    output logic [WIDTH-1:0]         core_x0,
    output logic [WIDTH-1:0]         core_y0,
    output logic [WIDTH-1:0]         core_z0,
    output logic [31:0]              core_n,
    input  logic [WIDTH-1:0]         core_x,
    input  logic [WIDTH-1:0]         core_y,
    input  logic [WIDTH-1:0]         core_z,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [IDW-1:0]           out_id,
    output logic [WIDTH-1:0]         out_x,
    output logic [WIDTH-1:0]         out_y,
    output logic [WIDTH-1:0]         out_z
);

    localparam int CW = $clog2(ITER + 1);
    localparam int SW = IDW + 1;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        RUN,
        HOLD
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic           any_req;
    logic [IDW-1:0] win;

    assign core_n = 32'(ITER);

`ifndef CORDIC_SCHED_FIXED_PRI_EN
    logic [IDW-1:0] ptr;
    logic [SW-1:0]  cand;

    // Round-robin search from ptr, wrapping modulo NUM_REQ; nearest asserted index wins
    always_comb begin
        any_req = 1'b0;
        win     = '0;
        cand    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = SW'(ptr) + SW'(k);
            if (cand >= SW'(NUM_REQ)) begin
                cand = cand - SW'(NUM_REQ);
            end
            if (req[cand[IDW-1:0]]) begin
                any_req = 1'b1;
                win     = cand[IDW-1:0];
            end
        end
    end
`else
    // Fixed priority search: the lowest asserted index wins
    always_comb begin
        any_req = 1'b0;
        win     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                any_req = 1'b1;
                win     = IDW'(k);
            end
        end
    end
`endif

    // Grant is decoded in the cycle the winner's operands are latched, so a requester sees it alongside the capture
    always_comb begin
        gnt = '0;
        if (state == IDLE && any_req && !rst) begin
            gnt[win] = 1'b1;
        end
    end

    // Sequencer: grant and latch, one-cycle core start, iteration countdown, hold result until accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            core_valid <= 1'b0;
            core_x0    <= '0;
            core_y0    <= '0;
            core_z0    <= '0;
            out_valid  <= 1'b0;
            out_id     <= '0;
            out_x      <= '0;
            out_y      <= '0;
            out_z      <= '0;
`ifndef CORDIC_SCHED_FIXED_PRI_EN
            ptr        <= '0;
`endif
        end else begin
            core_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        core_x0    <= req_x[int'(win)*WIDTH +: WIDTH];
                        core_y0    <= req_y[int'(win)*WIDTH +: WIDTH];
                        core_z0    <= req_z[int'(win)*WIDTH +: WIDTH];
                        out_id     <= win;
                        core_valid <= 1'b1;
                        state      <= LAUNCH;
`ifndef CORDIC_SCHED_FIXED_PRI_EN
                        ptr        <= (win == IDW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
`endif
                    end
                end
                LAUNCH: begin
                    cnt   <= CW'(ITER);
                    state <= RUN;
                end
                RUN: begin
                    if (cnt == '0) begin
                        out_x     <= core_x;
                        out_y     <= core_y;
                        out_z     <= core_z;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_sched.sv
// tb_cordic_sched: directed bench for cordic_sched with a scoreboard of expected results.
// A small core model returns operands perturbed by the number of cycles since the start
// pulse, so a capture on the wrong cycle or from the wrong slice changes the result.
module tb_cordic_sched;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 32;
    localparam int ITER    = 16;
    localparam int IDW     = 2;

    typedef struct {
        int          id;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] req_x;
    logic [NUM_REQ*WIDTH-1:0] req_y;
    logic [NUM_REQ*WIDTH-1:0] req_z;
    logic [NUM_REQ-1:0]       gnt;
    logic                     core_valid;
    logic [WIDTH-1:0]         core_x0;
    logic [WIDTH-1:0]         core_y0;
    logic [WIDTH-1:0]         core_z0;
    logic [31:0]              core_n;
    logic [WIDTH-1:0]         core_x;
    logic [WIDTH-1:0]         core_y;
    logic [WIDTH-1:0]         core_z;
    logic                     out_valid;
    logic                     out_ready;
    logic [IDW-1:0]           out_id;
    logic [WIDTH-1:0]         out_x;
    logic [WIDTH-1:0]         out_y;
    logic [WIDTH-1:0]         out_z;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          k = 0;
    int          grantCyc = 0;
    int          prevGrant = 0;
    int          hsCyc = 0;
    int          s2Ids[3];
    int          s6Ids[4];
    logic [31:0] opx[4];
    logic [31:0] opy[4];
    logic [31:0] opz[4];
    exp_t        sb[$];

    cordic_sched #(
        .NUM_REQ(NUM_REQ),
        .WIDTH  (WIDTH),
        .ITER   (ITER),
        .IDW    (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_z     (req_z),
        .gnt       (gnt),
        .core_valid(core_valid),
        .core_x0   (core_x0),
        .core_y0   (core_y0),
        .core_z0   (core_z0),
        .core_n    (core_n),
        .core_x    (core_x),
        .core_y    (core_y),
        .core_z    (core_z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_z     (out_z)
    );

    always #5 clk = ~clk;

    // Free-running cycle counter used for grant spacing
    always @(posedge clk) cyc <= cyc + 1;

    // Core model: iteration count restarts on the start pulse
    always @(posedge clk) k <= core_valid ? 0 : k + 1;

    assign core_x = core_x0 + 32'(3 * k);
    assign core_y = core_y0 ^ 32'(k << 4);
    assign core_z = core_z0 - 32'(k);

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] mask);
        req = mask;
    endtask

    // Expected result once the core has run ITER iterations on requester id's operands
    task automatic pushExpected(input int id);
        exp_t e;
        e.id = id;
        e.x  = opx[id] + 32'(3 * ITER);
        e.y  = opy[id] ^ 32'(ITER << 4);
        e.z  = opz[id] - 32'(ITER);
        sb.push_back(e);
    endtask

    task automatic checkResult(input string tag);
        exp_t e;
        checkOutput({tag, ".sbNonEmpty"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checkOutput({tag, ".outId"}, 64'(out_id), 64'(e.id));
            checkOutput({tag, ".outX"}, 64'(out_x), 64'(e.x));
            checkOutput({tag, ".outY"}, 64'(out_y), 64'(e.y));
            checkOutput({tag, ".outZ"}, 64'(out_z), 64'(e.z));
        end
    endtask

    task automatic waitGrant(input logic [NUM_REQ-1:0] expGnt, input string tag);
        int waited;
        waited = 0;
        #1;
        while (gnt == '0 && waited < 40) begin
            @(negedge clk);
            #1;
            waited++;
        end
        checkOutput({tag, ".gnt"}, 64'(gnt), 64'(expGnt));
        grantCyc = cyc;
    endtask

    // From the grant cycle, follow the start pulse and wait for out_valid
    task automatic finishOp(input string tag);
        int c;
        c = 0;
        while (c < 40) begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                checkOutput({tag, ".coreValid"}, 64'(core_valid), 64'd1);
                checkOutput({tag, ".gntPulse"}, 64'(gnt), 64'd0);
            end
            if (c == 2) begin
                checkOutput({tag, ".coreValidOff"}, 64'(core_valid), 64'd0);
            end
            if (out_valid) break;
        end
        checkOutput({tag, ".latency"}, 64'(c), 64'(ITER + 3));
    endtask

    // Watchdog in case a wait is left unbounded by a broken DUT
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic sawValid;
`ifdef CORDIC_SCHED_FIXED_PRI_EN
        s2Ids = '{1, 1, 1};
        s6Ids = '{0, 0, 0, 2};
`else
        s2Ids = '{1, 3, 1};
        s6Ids = '{2, 0, 2, 2};
`endif
        opx = '{32'h0001_0000, 32'h1234_5678, 32'hCAFE_0000, 32'h0F0F_0F0F};
        opy = '{32'h0000_0000, 32'h0000_1111, 32'h8000_0001, 32'hF0F0_F0F0};
        opz = '{32'h0020_0000, 32'hFFFF_FFF0, 32'h0000_0ABC, 32'h5555_AAAA};
        for (int i = 0; i < NUM_REQ; i++) begin
            req_x[i*WIDTH +: WIDTH] = opx[i];
            req_y[i*WIDTH +: WIDTH] = opy[i];
            req_z[i*WIDTH +: WIDTH] = opz[i];
        end
        rst       = 1'b1;
        req       = '0;
        out_ready = 1'b1;

        repeat (3) @(negedge clk);
        $display("[TB] reset values");
        checkOutput("reset.gnt", 64'(gnt), 64'd0);
        checkOutput("reset.coreValid", 64'(core_valid), 64'd0);
        checkOutput("reset.outValid", 64'(out_valid), 64'd0);
        checkOutput("reset.outId", 64'(out_id), 64'd0);
        checkOutput("reset.outX", 64'(out_x), 64'd0);
        checkOutput("reset.coreX0", 64'(core_x0), 64'd0);
        checkOutput("reset.coreN", 64'(core_n), 64'(ITER));
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle.gnt", 64'(gnt), 64'd0);

        $display("[TB] single request");
        applyStimulus(4'b0001);
        pushExpected(0);
        waitGrant(4'b0001, "single");
        finishOp("single");
        checkResult("single");
        req = '0;

        $display("[TB] contention");
        applyStimulus(4'b1010);
        for (int i = 0; i < 3; i++) pushExpected(s2Ids[i]);
        for (int i = 0; i < 3; i++) begin
            waitGrant(4'(1 << s2Ids[i]), "contend");
            if (i > 0) checkOutput("contend.spacing", 64'(grantCyc - prevGrant), 64'(ITER + 4));
            prevGrant = grantCyc;
            finishOp("contend");
            checkResult("contend");
        end
        req = '0;

        $display("[TB] back-pressure then wrap-around");
        applyStimulus(4'b0100);
        pushExpected(2);
        waitGrant(4'b0100, "backPressure");
        out_ready = 1'b0;
        finishOp("backPressure");
        applyStimulus(4'b0011);
        pushExpected(0);
        pushExpected(1);
        #1;
        for (int b = 0; b < 10; b++) begin
            checkOutput("backPressure.outValid", 64'(out_valid), 64'd1);
            checkOutput("backPressure.gnt", 64'(gnt), 64'd0);
            checkOutput("backPressure.stableX", 64'(out_x), 64'(sb[0].x));
            checkOutput("backPressure.stableId", 64'(out_id), 64'(sb[0].id));
            @(negedge clk);
        end
        out_ready = 1'b1;
        hsCyc = cyc;
        checkResult("backPressure");
        waitGrant(4'b0001, "wrapFirst");
        checkOutput("wrapFirst.gap", 64'(grantCyc - hsCyc), 64'd1);
        finishOp("wrapFirst");
        checkResult("wrapFirst");
        req = 4'b0010;
        waitGrant(4'b0010, "wrapSecond");
        finishOp("wrapSecond");
        checkResult("wrapSecond");
        req = '0;

        $display("[TB] reset mid-run");
        applyStimulus(4'b1000);
        waitGrant(4'b1000, "resetMid");
        repeat (8) @(negedge clk);
        req = '0;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("resetMid.gnt", 64'(gnt), 64'd0);
        checkOutput("resetMid.coreValid", 64'(core_valid), 64'd0);
        checkOutput("resetMid.outValid", 64'(out_valid), 64'd0);
        checkOutput("resetMid.outId", 64'(out_id), 64'd0);
        checkOutput("resetMid.outX", 64'(out_x), 64'd0);
        checkOutput("resetMid.coreX0", 64'(core_x0), 64'd0);
        rst = 1'b0;
        sawValid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) sawValid = 1'b1;
        end
        checkOutput("resetMid.noResult", 64'(sawValid), 64'd0);
        applyStimulus(4'b0010);
        pushExpected(1);
        waitGrant(4'b0010, "afterReset");
        finishOp("afterReset");
        checkResult("afterReset");
        req = '0;

        $display("[TB] priority pattern 0101");
        applyStimulus(4'b0101);
        for (int i = 0; i < 4; i++) pushExpected(s6Ids[i]);
        for (int i = 0; i < 3; i++) begin
            waitGrant(4'(1 << s6Ids[i]), "pri");
            finishOp("pri");
            checkResult("pri");
        end
        req = 4'b0100;
        waitGrant(4'(1 << s6Ids[3]), "priDrop");
        finishOp("priDrop");
        checkResult("priDrop");
        req = '0;

        repeat (3) @(negedge clk);
        checkOutput("end.outValid", 64'(out_valid), 64'd0);
        checkOutput("end.sbEmpty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cordic_sched.md
# cordic_sched

Round-robin scheduler that shares one iterative CORDIC rotation core among `NUM_REQ` requesters. It accepts one operand triple (x0, y0, z0) at a time and launches the core with a single-cycle start. It counts the core's iterations, captures the result and returns it on a valid/ready output tagged with the requester index. It sits between the angle/vector producers and the single `cordic_block` instance.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `WIDTH`, 32: operand and result width.
- `ITER`, 16: CORDIC iterations per operation; drives `core_n`.
- `IDW`, 2: width of `out_id`; must satisfy 2^IDW >= NUM_REQ.

Ports (clock and reset first):
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NUM_REQ  per-requester request, level, held until granted.
- `req_x`, `req_y`, `req_z`  in  NUM_REQ*WIDTH each  flattened operands; slice i = bits [i*WIDTH +: WIDTH]; valid whenever `req[i]`=1.
- `gnt`  out  NUM_REQ  one-hot, one-cycle pulse; operands of the granted slice are latched that cycle.
- `core_valid`  out  1  one-cycle start pulse to the core.
- `core_x0`, `core_y0`, `core_z0`  out  WIDTH  operands to the core, held stable from launch until capture.
- `core_n`  out  32  constant ITER.
- `core_x`, `core_y`, `core_z`  in  WIDTH  core results.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_id`  out  IDW  index of the requester that owns the result.
- `out_x`, `out_y`, `out_z`  out  WIDTH  captured results.

## Operation
- FSM states:
  - IDLE: if any `req` is set, pick a winner, pulse `gnt[w]`, latch its operands into the `core_*0` registers and the winner into `out_id`, then go to LAUNCH. If no request, stay in IDLE.
  - LAUNCH: `core_valid`=1 for exactly this cycle; load `cnt`=ITER; go to RUN.
  - RUN: decrement `cnt` each cycle. In the cycle with `cnt`=0, capture `core_x/y/z` into `out_x/y/z` and go to HOLD.
  - HOLD: `out_valid`=1. On `out_valid && out_ready`, go to IDLE. No new grant is issued in the handshake cycle.
- Arbitration is round-robin.
  - The search starts at `ptr` and wraps modulo NUM_REQ.
  - After a grant, `ptr` = winner+1 (wraps to 0).
  - `req` bits deasserted before a grant are simply ignored.
- Only one operation is in flight; `req` is ignored outside IDLE.
- `core_n` is tied to ITER; `cnt` is $clog2(ITER+1) bits.
- Outputs are registered. `out_*` hold their values after the handshake until the next capture.
- Reset values: `gnt`=0, `core_valid`=0, `core_x0/y0/z0`=0, `out_valid`=0, `out_id`=0, `out_x/y/z`=0, `ptr`=0, state=IDLE.
- Reset mid-operation (LAUNCH/RUN/HOLD) aborts the operation and drops any pending result without a handshake. The core itself is not reset; the next `core_valid` re-initialises it.

## Timing
- Cycle 0: grant (IDLE). Cycle 1: `core_valid`. Cycles 2..ITER+2: RUN. Capture at the end of cycle ITER+2.
- `out_valid` first high in cycle ITER+3.
- With ITER=16: grant at cycle 0, `out_valid` at cycle 19.
- Minimum spacing between grants is ITER+4 cycles (handshake in the first HOLD cycle, IDLE the next).
- Back-pressure extends HOLD without bound; `out_*` are stable while `out_valid`=1.
- A request that rises in the HOLD handshake cycle is granted in the following IDLE cycle.

## Configuration
- `CORDIC_SCHED_FIXED_PRI_EN`
  - Defined: fixed priority, lowest asserted index wins; `ptr` is removed.
  - Undefined (default): round-robin as above.
- Latency, FSM and handshake are identical in both builds.

## Test plan
- Single request: `req`=4'b0001, x0=0x00010000, y0=0, z0=0x00200000, ITER=16.
  - `gnt`=0001 at cycle 0 and `core_valid` at cycle 1.
  - `out_valid` at cycle 19 with `out_id`=0 and `out_*` equal to the core outputs at cycle 18.
- Contention: `req`=4'b1010 held.
  - First grant goes to index 1, then index 3, then index 1 again.
  - `gnt` pulses are ITER+4 cycles apart with `out_ready`=1.
- Back-pressure: `out_ready`=0 for 10 cycles after `out_valid` rises.
  - `out_*` stay stable and no `gnt` is issued.
  - The handshake on cycle 10 returns the FSM to IDLE, and the next grant follows one cycle later.
- Reset mid-RUN: assert `rst` at cycle 8.
  - The next cycle shows all outputs at reset values and `out_valid` never rises for that operation.
  - A fresh request afterwards completes normally in 19 cycles.
- Wrap-around: `ptr`=3 after granting index 2, with `req`=4'b0011.
  - Index 0 wins, then index 1.
- Fixed priority (`CORDIC_SCHED_FIXED_PRI_EN` defined): `req`=4'b0101 held.
  - Index 0 is granted every operation; index 2 is never granted until `req[0]` drops.
